// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath widths, control FSM encodings, shift fill modes.
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic ARITH = 1'b1;
  localparam logic LOGIC = 1'b0;
endpackage

// File: rtl/mux_2x1.sv
// Single-bit 2:1 mux, the primitive each barrel stage is built from.
module mux_2x1 (
  output logic out,
  input  logic a,
  input  logic b,
  input  logic sel
);
  assign out = sel ? b : a;
endmodule

// File: rtl/shift_right_stage.sv
// One barrel stage: passes a through, or shifts it right by amt with fill in the vacated bits.
module shift_right_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic             fill,
  input  logic             sel,
  input  logic [SHW-1:0]   amt
);
  logic [WIDTH-1:0] shifted;

  // amt is tied to a constant per instance, so this folds to plain wiring.
  assign shifted = (a >> amt) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> amt));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_2x1 u_mux (
      .out (out[i]),
      .a   (a[i]),
      .b   (shifted[i]),
      .sel (sel)
    );
  end
endmodule

// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter: one barrel stage (16,8,4,2,1) per cycle, fixed 6-cycle latency
// from accepted start to the done pulse.
module seq_shift_right #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int SHW   = alu_pkg::SHW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);
  import alu_pkg::*;

  localparam int KW = $clog2(SHW);

  state_t                    state, state_nxt;
  logic                      accept;
  logic [KW-1:0]             k;
  logic [SHW-1:0]            sh;
  logic                      arith_q;
  logic [WIDTH-1:0]          data, data_nxt;
  logic                      fill;
  logic [SHW-1:0]            en;
  logic [SHW-1:0][WIDTH-1:0] so;
  logic                      unused_b;

  assign unused_b = ^b[WIDTH-1:SHW];

  // Sign bit never changes under an arithmetic shift, so per-stage fill stays correct.
  assign fill = (arith_q == ARITH) & data[WIDTH-1];
  assign en   = SHW'(1) << k;

  for (genvar j = 0; j < SHW; j++) begin : g_stage
    shift_right_stage #(.WIDTH(WIDTH), .SHW(SHW)) u_stage (
      .out  (so[j]),
      .a    (data),
      .fill (fill),
      .sel  (sh[j]),
      .amt  (SHW'(1 << j))
    );
  end

  always_comb begin
    data_nxt = data;
    for (int j = 0; j < SHW; j++)
      if (en[j]) data_nxt = so[j];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (k == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data    <= '0;
      k       <= KW'(SHW-1);
      sh      <= '0;
      arith_q <= LOGIC;
    end else if (accept) begin
      data    <= a;
      k       <= KW'(SHW-1);
      sh      <= b[SHW-1:0];
      arith_q <= arith;
    end else if (state == ST_SHIFT) begin
      data <= data_nxt;
      k    <= (k == '0) ? KW'(SHW-1) : k - KW'(1);
    end
  end

  assign out  = data;
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);
endmodule

// File: doc/seq_shift_right.md
# seq_shift_right

Multi-cycle right shifter: the right-shift counterpart to the left-shift stages of the ALU datapath. It accepts a 32-bit operand and a 5-bit shift amount, then applies one barrel stage per cycle (16, 8, 4, 2, 1), each stage built from `mux_2x1`. It supports logical (zero fill) and arithmetic (sign fill) shifts. Latency is fixed, with a start/busy/done handshake toward the ALU control FSM.

## Interface
Parameters:
- `WIDTH`, 32, operand width. Fixed at 32; other values are not supported.
- `SHW`, 5, shift-amount width (log2 `WIDTH`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only when `busy` = 0.
- `a`  in  32  operand. Captured on an accepted `start`.
- `b`  in  32  shift amount. Only `b[4:0]` is used; `b[31:5]` is ignored. Captured on an accepted `start`.
- `arith`  in  1  fill select: 1 = arithmetic (fill with `a[31]`), 0 = logical (fill with 0). Captured on an accepted `start`.
- `out`  out  32  result register. Holds its value until the next result or reset.
- `busy`  out  1  high while stages are being applied.
- `done`  out  1  one-cycle pulse when `out` is valid.

## Operation
- States:
  - IDLE: `busy` = 0, `done` = 0.
  - SHIFT: `busy` = 1, stage counter `k` counts 4 down to 0.
  - DONE: `done` = 1, `busy` = 0.
- IDLE → SHIFT on `start`. The data register is loaded with `a`; `b[4:0]` and `arith` are latched; `k` = 4.
- Each SHIFT cycle:
  - If latched `sh[k]` = 1, data ← data >> 2^k, with the vacated upper 2^k bits filled by the fill bit. Otherwise data is unchanged.
  - `k` decrements.
  - After the `k` = 0 stage, go to DONE.
- Fill bit = `arith & data[31]`. The sign bit is invariant under an arithmetic shift, so stage-by-stage sign fill equals a single arithmetic shift by `sh`.
- DONE: `out` presents the result. Next state:
  - SHIFT if `start` = 1 (back-to-back; new operands captured).
  - IDLE otherwise.
- `start` while `busy` = 1 is ignored. No queuing and no error.
- Shift amount 0 still takes the full latency; result = `a`.
- Shift amount 31:
  - logical: result = `{31'b0, a[31]}`.
  - arithmetic: result = all `a[31]`.
- `out` is the data register itself. During SHIFT it shows intermediate values; consumers sample it only when `done` = 1 or afterwards.

## Timing
- `start` high in cycle N (accepted): `busy` high in cycles N+1..N+5, `done` high in cycle N+6, result on `out` from N+6 until the next accepted `start` + 1.
- Latency is always 6 cycles from accept to `done`, independent of the shift amount. Throughput is one operation per 6 cycles with back-to-back `start` in the DONE cycle.
- Reset (sync, any state, including mid-SHIFT or DONE): next cycle state = IDLE, `out` = 0, `busy` = 0, `done` = 0, `k` = 4, latched `sh`/`arith` = 0.
- `reset` and `start` high together: reset wins and `start` is dropped.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package/header `alu_pkg`:
  - `WIDTH` = 32 and `SHW` = 5.
  - FSM state encodings `ST_IDLE` = 2'd0, `ST_SHIFT` = 2'd1, `ST_DONE` = 2'd2.
  - `ARITH` = 1'b1 and `LOGIC` = 1'b0.
- Sub-module `shift_right_stage`:
  - Ports: `out`, `a`, `fill`, `sel`, `amt`.
  - Each output bit is a `mux_2x1` choosing `a[i]` or `a[i+amt]`/`fill`.
  - Five instances, `amt` = 16/8/4/2/1.
  - The top selects the stage output by `k` (one-hot enable from `k`) and writes it into the data register.

## Test plan
- `a` = 0x80000000, `b` = 4, `arith` = 0 → `done` at N+6, `out` = 0x08000000. Repeat with `arith` = 1 → `out` = 0xF8000000.
- `a` = 0xFFFFFFFF, `b` = 0x00000025 (low bits = 5), `arith` = 0 → `out` = 0x07FFFFFF. Confirms upper `b` bits are ignored.
- `a` = 0x12345678, `b` = 0 → `out` = 0x12345678 at N+6. Then `b` = 31 logical → `out` = 0x00000000; arithmetic with `a` = 0x9234ABCD → `out` = 0xFFFFFFFF.
- `start` pulsed at N+2 with different operands during a busy op → ignored; first result is unaffected and `done` occurs once. A `start` in the DONE cycle → second `done` at N+12 with the correct second result.
- `reset` asserted at N+3 mid-shift → next cycle `out` = 0, `busy` = 0, `done` = 0, no `done` pulse follows. A new `start` afterwards completes normally.
- Random sweep of 1000 (`a`, `b`, `arith`) ops against a reference model (`>>` / `>>>`). Check `out` at every `done`, `busy` width = 5, and exactly one `done` per accepted `start`.
